can_tx_serializer: RTL and testbench

Consumes the bit-rate strobe from can_clk_gen (clock_pulse_out_o → bit_tick_i) and serializes one CAN 2.0A standard data frame per request onto the TX line. Covers field sequencing, CRC-15 generation and bit stuffing. Sits between the frame-request logic and the CAN transceiver TX pin. No arbitration-loss or ACK checking; the ACK slot is sent recessive.

---
 rtl/can_pkg.sv | 34 +++
 rtl/can_crc15.sv | 28 ++
 rtl/can_tx_serializer.sv | 210 +++++++++++++++++++++
 tb/tb_can_tx_serializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared constants, state encoding and the CRC-15 step function for the CAN
// standard-frame transmitter.
package can_pkg;

  localparam int unsigned IdW        = 11;
  localparam int unsigned DlcW       = 4;
  localparam int unsigned CrcW       = 15;
  localparam int unsigned DataW      = 64;
  localparam int unsigned HdrLen     = 19;
  localparam int unsigned TrlLen     = 13;
  localparam int unsigned StuffLimit = 5;

  localparam logic [CrcW-1:0] CrcPoly = 15'h4599;

  typedef enum logic [1:0] {
    StIdle,
    StStuffed,
    StCrc,
    StTrailer
  } tx_state_e;

  // One serial CRC-15 update: shift left, fold in the polynomial when the
  // incoming bit differs from the outgoing MSB.
  function automatic logic [CrcW-1:0] crc15_step(input logic [CrcW-1:0] crc,
                                                 input logic            b);
    logic [CrcW-1:0] nxt;
    nxt = {crc[CrcW-2:0], 1'b0};
    if (b ^ crc[CrcW-1]) begin
      nxt = nxt ^ CrcPoly;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 accumulator; cleared per frame, advanced once per
// unstuffed header/data bit.
module can_crc15
  import can_pkg::*;
(
  input  logic            clock_in_i,
  input  logic            reset_i,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic            bit_i,
  output logic [CrcW-1:0] crc_o
);

  logic [CrcW-1:0] crc_q;

  always_ff @(posedge clock_in_i or posedge reset_i) begin
    if (reset_i) begin
      crc_q <= '0;
    end else if (clear_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc15_step(crc_q, bit_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/can_tx_serializer.sv
// Serializes one CAN 2.0A data frame per request: header/data with stuffing,
// CRC-15 field, then 13 recessive trailer bits. Advances only on bit ticks.
module can_tx_serializer
  import can_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 8
) (
  input  logic             clock_in_i,
  input  logic             reset_i,
  input  logic             bit_tick_i,
  input  logic             frame_valid_i,
  output logic             frame_ready_o,
  input  logic [IdW-1:0]   id_i,
  input  logic [DlcW-1:0]  dlc_i,
  input  logic [DataW-1:0] data_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned FrameW   = HdrLen + DataW;
  localparam logic [6:0]  FrameMsb = 7'(FrameW - 1);
  localparam logic [6:0]  CrcLast  = 7'(CrcW - 1);
  localparam logic [6:0]  CrcPend  = 7'(CrcW);

  tx_state_e        state_q, state_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [DlcW-1:0]  dlc_q, dlc_d;
  logic [DataW-1:0] data_q, data_d;
  logic [6:0]       last_idx_q, last_idx_d;
  logic [6:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       run_cnt_q, run_cnt_d;
  logic             run_bit_q, run_bit_d;
  logic [3:0]       trl_cnt_q, trl_cnt_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic             accept;
  logic [3:0]       nbytes;
  logic [FrameW-1:0] frame_vec;
  logic             field_bit;
  logic [CrcW-1:0]  crc;
  logic [CrcW:0]    crc_ext;
  logic [3:0]       crc_sel;
  logic             crc_bit;
  logic             stuff_due;
  logic             tx_bit;
  logic [2:0]       new_run;
  logic             crc_clear;
  logic             crc_en;

  assign accept = frame_valid_i && ready_q;
  assign nbytes = (32'(dlc_i) > MAX_BYTES) ? 4'(MAX_BYTES) : dlc_i;

  // SOF, ID, RTR, IDE, r0, DLC, then payload; indexed MSB-first by bit_idx_q.
  assign frame_vec = {1'b0, id_q, 3'b000, dlc_q, data_q};
  assign field_bit = frame_vec[FrameMsb - bit_idx_q];

  // The extra zero bit keeps the index in range while a post-CRC stuff bit
  // is pending (bit_idx_q == CrcPend); that value is never transmitted.
  assign crc_ext = {1'b0, crc};
  assign crc_sel = 4'(CrcW - 1) - bit_idx_q[3:0];
  assign crc_bit = crc_ext[crc_sel];

  assign stuff_due = (run_cnt_q == 3'(StuffLimit));
  assign tx_bit    = stuff_due ? ~run_bit_q
                   : ((state_q == StStuffed) ? field_bit : crc_bit);
  assign new_run   = (run_cnt_q != 3'd0 && tx_bit == run_bit_q) ? run_cnt_q + 3'd1 : 3'd1;

  can_crc15 u_crc (
    .clock_in_i (clock_in_i),
    .reset_i    (reset_i),
    .clear_i    (crc_clear),
    .en_i       (crc_en),
    .bit_i      (field_bit),
    .crc_o      (crc)
  );

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    last_idx_d = last_idx_q;
    bit_idx_d  = bit_idx_q;
    run_cnt_d  = run_cnt_q;
    run_bit_d  = run_bit_q;
    trl_cnt_d  = trl_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          id_d       = id_i;
          dlc_d      = dlc_i;
          data_d     = data_i;
          last_idx_d = 7'(HdrLen) + {nbytes, 3'b000} - 7'd1;
          bit_idx_d  = '0;
          run_cnt_d  = '0;
          trl_cnt_d  = '0;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
          crc_clear  = 1'b1;
          state_d    = StStuffed;
        end
      end

      StStuffed: begin
        if (bit_tick_i) begin
          tx_d      = tx_bit;
          run_cnt_d = new_run;
          run_bit_d = tx_bit;
          if (!stuff_due) begin
            crc_en = 1'b1;
            if (bit_idx_q == last_idx_q) begin
              bit_idx_d = '0;
              state_d   = StCrc;
            end else begin
              bit_idx_d = bit_idx_q + 7'd1;
            end
          end
        end
      end

      StCrc: begin
        if (bit_tick_i) begin
          tx_d      = tx_bit;
          run_cnt_d = new_run;
          run_bit_d = tx_bit;
          if (stuff_due) begin
            if (bit_idx_q == CrcPend) begin
              run_cnt_d = '0;
              state_d   = StTrailer;
            end
          end else if (bit_idx_q == CrcLast) begin
            if (new_run == 3'(StuffLimit)) begin
              bit_idx_d = CrcPend;
            end else begin
              run_cnt_d = '0;
              state_d   = StTrailer;
            end
          end else begin
            bit_idx_d = bit_idx_q + 7'd1;
          end
        end
      end

      StTrailer: begin
        if (bit_tick_i) begin
          tx_d = 1'b1;
          if (trl_cnt_q == 4'(TrlLen)) begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            trl_cnt_d = trl_cnt_q + 4'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_in_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      id_q       <= '0;
      dlc_q      <= '0;
      data_q     <= '0;
      last_idx_q <= '0;
      bit_idx_q  <= '0;
      run_cnt_q  <= '0;
      run_bit_q  <= 1'b1;
      trl_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      dlc_q      <= dlc_d;
      data_q     <= data_d;
      last_idx_q <= last_idx_d;
      bit_idx_q  <= bit_idx_d;
      run_cnt_q  <= run_cnt_d;
      run_bit_q  <= run_bit_d;
      trl_cnt_q  <= trl_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign tx_o          = tx_q;
  assign busy_o        = busy_q;
  assign frame_ready_o = ready_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_can_tx_serializer.sv
// Directed bench for can_tx_serializer: captures tx_o after every tick and
// compares against an independent frame/CRC/stuffing reference.
module tb_can_tx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        valid = 1'b0;
  logic [10:0] id = '0;
  logic [3:0]  dlc = '0;
  logic [63:0] data = '0;
  logic        tx, ready, busy, done;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int rdy_busy_err = 0;

  bit exp_q[$];
  bit cap[$];
  bit s1_cap[$];
  int irregular[3] = '{1, 3, 57};

  can_tx_serializer #(.MAX_BYTES(8)) dut (
    .clock_in_i    (clk),
    .reset_i       (rst),
    .bit_tick_i    (tick),
    .frame_valid_i (valid),
    .frame_ready_o (ready),
    .id_i          (id),
    .dlc_i         (dlc),
    .data_i        (data),
    .tx_o          (tx),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (valid && ready) acc_cnt <= acc_cnt + 1;
    if (busy && ready) rdy_busy_err <= rdy_busy_err + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Reference: raw header+data, CRC over it, stuff through CRC, 13 ones.
  task automatic build_frame(input logic [10:0] fid, input logic [3:0] fdlc,
                             input logic [63:0] fdata);
    bit raw[$];
    logic [14:0] c;
    logic fb;
    int nb;
    int run;
    bit last;
    raw.delete();
    exp_q.delete();
    nb = (fdlc > 4'd8) ? 8 : int'(fdlc);
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(fid[i]);
    repeat (3) raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(fdlc[i]);
    for (int i = 0; i < 8 * nb; i++) raw.push_back(fdata[63 - i]);
    c = '0;
    foreach (raw[i]) begin
      fb = raw[i] ^ c[14];
      c = {c[13:0], 1'b0};
      if (fb) c = c ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    run = 0;
    last = 1'b0;
    foreach (raw[i]) begin
      if (run == 5) begin
        exp_q.push_back(~last);
        last = ~last;
        run = 1;
      end
      exp_q.push_back(raw[i]);
      if (run > 0 && raw[i] == last) run++;
      else run = 1;
      last = raw[i];
    end
    if (run == 5) exp_q.push_back(~last);
    repeat (13) exp_q.push_back(1'b1);
  endtask

  // per == 0 selects the irregular 1/3/57 tick period pattern.
  task automatic run_frame(input string nm, input logic [10:0] fid, input logic [3:0] fdlc,
                           input logic [63:0] fdata, input int per, input bit pre,
                           input bit hold, input bit keep, input bit acc_tick,
                           input int abort_at);
    int hold_err;
    int d0;
    int p;
    logic last_tx;
    hold_err = 0;
    d0 = done_cnt;
    build_frame(fid, fdlc, fdata);
    cap.delete();
    if (!pre) begin
      @(negedge clk);
      valid = 1'b1;
      id = fid;
      dlc = fdlc;
      data = fdata;
      tick = acc_tick;
      @(negedge clk);
      valid = hold;
      tick = 1'b0;
      check({nm, "_busy_acc"}, 64'(busy), 64'd1);
      check({nm, "_ready_acc"}, 64'(ready), 64'd0);
    end
    check({nm, "_tx_pre_sof"}, 64'(tx), 64'd1);
    last_tx = tx;
    for (int i = 0; i <= exp_q.size(); i++) begin
      p = (per != 0) ? per : irregular[i % 3];
      repeat (p - 1) begin
        @(negedge clk);
        if (tx !== last_tx) hold_err++;
      end
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (i < exp_q.size()) begin
        cap.push_back(tx);
        check($sformatf("%s_bit%0d", nm, i), 64'(tx), 64'(exp_q[i]));
        last_tx = tx;
        if (abort_at == i + 1) begin
          #2 rst = 1'b1;
          #1;
          check({nm, "_rst_tx"}, 64'(tx), 64'd1);
          check({nm, "_rst_ready"}, 64'(ready), 64'd1);
          check({nm, "_rst_busy"}, 64'(busy), 64'd0);
          @(negedge clk);
          rst = 1'b0;
          repeat (3) @(negedge clk);
          check({nm, "_rst_no_done"}, 64'(done_cnt - d0), 64'd0);
          check({nm, "_rst_idle_tx"}, 64'(tx), 64'd1);
          return;
        end
      end else begin
        check({nm, "_done"}, 64'(done), 64'd1);
        check({nm, "_busy_end"}, 64'(busy), 64'd0);
        check({nm, "_ready_end"}, 64'(ready), 64'd1);
        if (!keep) valid = 1'b0;
      end
    end
    check({nm, "_tx_hold"}, 64'(hold_err), 64'd0);
    @(negedge clk);
    check({nm, "_done_pulse"}, 64'(done), 64'd0);
    check({nm, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({nm, "_ready_after"}, 64'(ready), 64'(!keep));
  endtask

  initial begin
    logic [19:0] h20;
    logic [11:0] h12;
    int a0;
    #1 rst = 1'b1;
    #1;
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: alternating ID, DLC 0, slow ticks
    run_frame("s1", 11'h555, 4'd0, 64'd0, 200, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    h20 = '0;
    for (int i = 0; i < 20; i++) h20 = {h20[18:0], cap[i]};
    check("s1_hand_bits", 64'(h20), 64'h55504);
    s1_cap = cap;

    // 2: all-zero frame with a tick on the accept cycle
    run_frame("s2", 11'h000, 4'd1, 64'd0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    h12 = '0;
    for (int i = 0; i < 12; i++) h12 = {h12[10:0], cap[i]};
    check("s2_hand_bits", 64'(h12), 64'h041);

    // 3: DLC above the clamp
    run_frame("s3", 11'h7A3, 4'd15, 64'h0123456789ABCDEF, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // 4: irregular tick spacing, same frame as scenario 1
    run_frame("s4", 11'h555, 4'd0, 64'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("s4_same_as_s1", 64'(cap == s1_cap), 64'd1);

    // 5: frame_valid held across two frames
    a0 = acc_cnt;
    run_frame("s5a", 11'h123, 4'd2, 64'hA5C3000000000000, 2, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    run_frame("s5b", 11'h123, 4'd2, 64'hA5C3000000000000, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("s5_accepts", 64'(acc_cnt - a0), 64'd2);

    // 6: reset during DLC, then a clean frame
    run_frame("s6a", 11'h555, 4'd0, 64'd0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    run_frame("s6b", 11'h0F0, 4'd3, 64'hFFFF000000000000, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    check("ready_during_busy", 64'(rdy_busy_err), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
